regfile_write_arbiter: RTL and testbench

- Shares the single write port of the register block between two writeback requesters: A (ALU result) and B (load result).
- Each requester uses a req/ack handshake; grants are round-robin.
- Also keeps a per-register busy scoreboard, so issue logic can stall reads of registers that have a pending write.
- Sits between the execute/memory stages and the register block; drives its regWrite, write_reg, write_data and byteOperations inputs.

---
 rtl/regfile_pkg.sv | 22 ++
 rtl/regfile_scoreboard.sv | 48 ++++
 rtl/regfile_write_arbiter.sv | 118 +++++++++++
 tb/tb_regfile_write_arbiter.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
`default_nettype none
// Shared constants and enumerations for the register-file write arbiter.
package regfile_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;
  localparam int ZERO_REG = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR_A = 2'd1,
    ST_WR_B = 2'd2
  } state_t;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_t;

endpackage
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// Per-register busy bits: set on reservation, cleared on write grant;
// a reservation and a clear of the same register at one edge leaves it busy.
module regfile_scoreboard #(
  parameter int ADDR_W   = regfile_pkg::ADDR_W,
  parameter int NUM_REGS = regfile_pkg::NUM_REGS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                set_valid,
  input  logic [ADDR_W-1:0]   set_reg,
  input  logic                clr_valid,
  input  logic [ADDR_W-1:0]   clr_reg,
  input  logic [ADDR_W-1:0]   chk_reg1,
  input  logic [ADDR_W-1:0]   chk_reg2,
  output logic                stall,
  output logic [NUM_REGS-1:0] busy_vec
);
  import regfile_pkg::*;

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  always_comb begin
    busy_d = busy_q;
    if (clr_valid) begin
      busy_d[clr_reg] = 1'b0;
    end
    // Applied after the clear so a newly issued producer keeps the register busy.
    if (set_valid && (set_reg != ADDR_W'(ZERO_REG))) begin
      busy_d[set_reg] = 1'b1;
    end
    busy_d[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign stall    = busy_q[chk_reg1] | busy_q[chk_reg2];
  assign busy_vec = busy_q;

endmodule
`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// Round-robin arbiter sharing the register-file write port between the ALU (A)
// and load (B) writeback paths, with a busy scoreboard for issue stalls.
module regfile_write_arbiter #(
  parameter int DATA_W   = regfile_pkg::DATA_W,
  parameter int ADDR_W   = regfile_pkg::ADDR_W,
  parameter int NUM_REGS = regfile_pkg::NUM_REGS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rsv_valid,
  input  logic [ADDR_W-1:0]   rsv_reg,
  input  logic                a_req,
  input  logic [ADDR_W-1:0]   a_reg,
  input  logic [DATA_W-1:0]   a_data,
  input  logic                a_byte,
  output logic                a_ack,
  input  logic                b_req,
  input  logic [ADDR_W-1:0]   b_reg,
  input  logic [DATA_W-1:0]   b_data,
  input  logic                b_byte,
  output logic                b_ack,
  output logic                rf_we,
  output logic [ADDR_W-1:0]   rf_waddr,
  output logic [DATA_W-1:0]   rf_wdata,
  output logic                rf_byte,
  input  logic [ADDR_W-1:0]   chk_reg1,
  input  logic [ADDR_W-1:0]   chk_reg2,
  output logic                stall,
  output logic [NUM_REGS-1:0] busy_vec
);
  import regfile_pkg::*;

  state_t              state_q;
  state_t              state_d;
  req_id_t             ptr_q;
  logic                rf_we_q;
  logic [ADDR_W-1:0]   rf_waddr_q;
  logic [DATA_W-1:0]   rf_wdata_q;
  logic                rf_byte_q;
  logic                a_elig;
  logic                b_elig;
  logic                clr_valid;
  logic [ADDR_W-1:0]   clr_reg;

  // The ack is high exactly while in WR_x, so it doubles as the re-grant mask.
  assign a_elig = a_req && (state_q != ST_WR_A);
  assign b_elig = b_req && (state_q != ST_WR_B);

  always_comb begin
    state_d = ST_IDLE;
    if (a_elig && (!b_elig || (ptr_q == REQ_A))) begin
      state_d = ST_WR_A;
    end else if (b_elig) begin
      state_d = ST_WR_B;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ptr_q      <= REQ_A;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      rf_byte_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rf_we_q <= 1'b0;
      case (state_d)
        ST_WR_A: begin
          rf_we_q    <= (a_reg != ADDR_W'(ZERO_REG));
          rf_waddr_q <= a_reg;
          rf_wdata_q <= a_data;
          rf_byte_q  <= a_byte;
          ptr_q      <= REQ_B;
        end
        ST_WR_B: begin
          rf_we_q    <= (b_reg != ADDR_W'(ZERO_REG));
          rf_waddr_q <= b_reg;
          rf_wdata_q <= b_data;
          rf_byte_q  <= b_byte;
          ptr_q      <= REQ_A;
        end
        default: begin
        end
      endcase
    end
  end

  assign a_ack    = (state_q == ST_WR_A);
  assign b_ack    = (state_q == ST_WR_B);
  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign rf_byte  = rf_byte_q;

  assign clr_valid = (state_d != ST_IDLE);
  assign clr_reg   = (state_d == ST_WR_B) ? b_reg : a_reg;

  regfile_scoreboard #(
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS)
  ) u_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .set_valid (rsv_valid),
    .set_reg   (rsv_reg),
    .clr_valid (clr_valid),
    .clr_reg   (clr_reg),
    .chk_reg1  (chk_reg1),
    .chk_reg2  (chk_reg2),
    .stall     (stall),
    .busy_vec  (busy_vec)
  );

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// Directed self-checking bench for regfile_write_arbiter.
module tb_regfile_write_arbiter;

  logic        clk;
  logic        rst_n;
  logic        rsv_valid;
  logic [4:0]  rsv_reg;
  logic        a_req;
  logic [4:0]  a_reg;
  logic [31:0] a_data;
  logic        a_byte;
  logic        a_ack;
  logic        b_req;
  logic [4:0]  b_reg;
  logic [31:0] b_data;
  logic        b_byte;
  logic        b_ack;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        rf_byte;
  logic [4:0]  chk_reg1;
  logic [4:0]  chk_reg2;
  logic        stall;
  logic [31:0] busy_vec;

  int n_checks;
  int n_fail;

  regfile_write_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rsv_valid (rsv_valid),
    .rsv_reg   (rsv_reg),
    .a_req     (a_req),
    .a_reg     (a_reg),
    .a_data    (a_data),
    .a_byte    (a_byte),
    .a_ack     (a_ack),
    .b_req     (b_req),
    .b_reg     (b_reg),
    .b_data    (b_data),
    .b_byte    (b_byte),
    .b_ack     (b_ack),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .rf_byte   (rf_byte),
    .chk_reg1  (chk_reg1),
    .chk_reg2  (chk_reg2),
    .stall     (stall),
    .busy_vec  (busy_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b1;
    rsv_valid = 1'b0;
    rsv_reg   = '0;
    a_req     = 1'b0;
    a_reg     = '0;
    a_data    = '0;
    a_byte    = 1'b0;
    b_req     = 1'b0;
    b_reg     = '0;
    b_data    = '0;
    b_byte    = 1'b0;
    chk_reg1  = '0;
    chk_reg2  = '0;
    #1 rst_n = 1'b0;
    tick();
    tick();
    check_val("rst_we",    rf_we, 0);
    check_val("rst_waddr", rf_waddr, 0);
    check_val("rst_wdata", rf_wdata, 0);
    check_val("rst_byte",  rf_byte, 0);
    check_val("rst_acks",  {a_ack, b_ack}, 0);
    check_val("rst_busy",  busy_vec, 0);
    check_val("rst_stall", stall, 0);
    rst_n = 1'b1;

    // Single write from A
    a_req = 1'b1; a_reg = 5'd5; a_data = 32'h0000_00AB; a_byte = 1'b0;
    tick();
    check_val("t1_we",    rf_we, 1);
    check_val("t1_waddr", rf_waddr, 5);
    check_val("t1_wdata", rf_wdata, 32'hAB);
    check_val("t1_acks",  {a_ack, b_ack}, 2'b10);
    tick();
    check_val("t1_idle_we",  rf_we, 0);
    check_val("t1_idle_ack", {a_ack, b_ack}, 2'b00);
    a_req = 1'b0;
    tick();
    check_val("t1_quiet", {rf_we, a_ack, b_ack}, 0);

    // Both requesting from reset: strict alternation starting with A
    rst_n = 1'b0;
    a_req = 1'b1; a_reg = 5'd3; a_data = 32'h33;
    b_req = 1'b1; b_reg = 5'd4; b_data = 32'h44; b_byte = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_val($sformatf("t2_acks%0d", i), {a_ack, b_ack}, (i % 2 == 0) ? 2'b10 : 2'b01);
      check_val($sformatf("t2_waddr%0d", i), rf_waddr, (i % 2 == 0) ? 5'd3 : 5'd4);
      check_val($sformatf("t2_wdata%0d", i), rf_wdata, (i % 2 == 0) ? 32'h33 : 32'h44);
    end
    a_req = 1'b0; b_req = 1'b0;
    tick();
    check_val("t2_idle", {rf_we, a_ack, b_ack}, 0);

    // B writes register 0 while reg 12 is reserved
    rsv_valid = 1'b1; rsv_reg = 5'd12;
    tick();
    rsv_valid = 1'b0;
    check_val("t3_rsv12", busy_vec, 32'h0000_1000);
    b_req = 1'b1; b_reg = 5'd0; b_data = 32'hFFFF_FFFF; b_byte = 1'b1;
    tick();
    check_val("t3_back",  {a_ack, b_ack}, 2'b01);
    check_val("t3_we",    rf_we, 0);
    check_val("t3_wdata", rf_wdata, 32'hFFFF_FFFF);
    check_val("t3_byte",  rf_byte, 1);
    check_val("t3_busy",  busy_vec, 32'h0000_1000);
    tick();
    b_req = 1'b0; b_byte = 1'b0;

    // Reservation of reg 7 visible only after the edge; A's grant clears it
    rsv_valid = 1'b1; rsv_reg = 5'd7; chk_reg1 = 5'd7; chk_reg2 = 5'd0;
    #1;
    check_val("t4_stall_pre", stall, 0);
    tick();
    rsv_valid = 1'b0;
    check_val("t4_stall_set", stall, 1);
    check_val("t4_busy_set",  busy_vec, 32'h0000_1080);
    a_req = 1'b1; a_reg = 5'd7; a_data = 32'h77;
    tick();
    check_val("t4_aack",     {a_ack, b_ack}, 2'b10);
    check_val("t4_we",       rf_we, 1);
    check_val("t4_stall_cl", stall, 0);
    check_val("t4_busy_cl",  busy_vec, 32'h0000_1000);
    chk_reg1 = 5'd0; chk_reg2 = 5'd12;
    #1;
    check_val("t4_stall_r2", stall, 1);
    tick();
    a_req = 1'b0; chk_reg2 = 5'd0;

    // Reservation and B's grant to reg 9 at the same edge: set wins
    rsv_valid = 1'b1; rsv_reg = 5'd9;
    tick();
    b_req = 1'b1; b_reg = 5'd9; b_data = 32'h99;
    tick();
    rsv_valid = 1'b0;
    check_val("t5_back", {a_ack, b_ack}, 2'b01);
    check_val("t5_busy", busy_vec, 32'h0000_1200);
    tick();
    b_req = 1'b0;
    tick();

    // Async reset in the middle of WR_A, then re-grant of the held request
    a_req = 1'b1; a_reg = 5'd10; a_data = 32'h0000_A5A5;
    tick();
    check_val("t6_pre_ack", {a_ack, rf_we}, 2'b11);
    #2 rst_n = 1'b0;
    #1;
    check_val("t6_rst_out", {rf_we, a_ack, b_ack, rf_byte}, 0);
    check_val("t6_rst_addr", rf_waddr, 0);
    check_val("t6_rst_data", rf_wdata, 0);
    check_val("t6_rst_busy", busy_vec, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check_val("t6_regrant", {a_ack, b_ack, rf_we}, 3'b101);
    check_val("t6_waddr",   rf_waddr, 10);
    tick();
    check_val("t6_gap", a_ack, 0);
    tick();
    check_val("t6_again", a_ack, 1);
    a_req = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
